// File: rtl/csa_pkg.sv
// Shared definitions for the streaming multi-word carry-select adder.
package csa_pkg;

   localparam int LIMB_W        = 16;
   localparam int MAX_LIMBS_DEF = 8;

   typedef enum logic {
      FIRST = 1'b0,
      MID   = 1'b1
   } state_t;

endpackage

// File: rtl/csa_16bit.sv
// 16-bit carry-select adder: 4-bit blocks, each pre-computing sums for carry-in 0 and 1.
module csa_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [4:0] c;

   assign c[0] = cin;

   for (genvar g = 0; g < 4; g++) begin : g_blk
      logic [4:0] s0;
      logic [4:0] s1;
      assign s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
      assign s1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
      assign sum[4*g +: 4] = c[g] ? s1[3:0] : s0[3:0];
      assign c[g+1]        = c[g] ? s1[4]   : s0[4];
   end

   assign cout = c[4];

endmodule

// File: rtl/csa_multiword_adder.sv
// Streaming multi-word adder: chains csa_16bit carries across limbs of a packet.
// Optional subtract mode (in_sub port) is enabled by defining CSA_MULTIWORD_SUB_EN.
//
// state | meaning
// FIRST | next accepted limb starts a packet; adder carry-in comes from in_cin
// MID   | inside a packet; adder carry-in comes from carry_q
module csa_multiword_adder
   import csa_pkg::*;
#(
   parameter int WIDTH     = LIMB_W,
   parameter int MAX_LIMBS = MAX_LIMBS_DEF,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_last,
`ifdef CSA_MULTIWORD_SUB_EN
   input  logic             in_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_last,
   output logic             out_cout,
   output logic             out_err
);

   state_t           state_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_sum_q;
   logic             out_last_q;
   logic             out_cout_q;
   logic             out_err_q;

   logic             accept;
   logic             sub_d;
   logic [WIDTH-1:0] b_d;
   logic             cin_d;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic             trunc_d;
   logic             last_d;

`ifdef CSA_MULTIWORD_SUB_EN
   logic             sub_q;

   assign sub_d = (state_q == FIRST) ? in_sub : sub_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sub_q <= 1'b0;
      end else if (accept && (state_q == FIRST)) begin
         sub_q <= in_sub;
      end
   end
`else
   assign sub_d = 1'b0;
`endif

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Subtraction is A + ~B + 1; the +1 rides on the first-limb carry-in.
   assign b_d   = in_b ^ {WIDTH{sub_d}};
   assign cin_d = (state_q == FIRST) ? (sub_d | in_cin) : carry_q;

   csa_16bit u_csa (
      .a    (in_a),
      .b    (b_d),
      .cin  (cin_d),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign trunc_d = (state_q == MID) && (cnt_q == CNT_W'(MAX_LIMBS - 1)) && !in_last;
   assign last_d  = in_last || trunc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FIRST;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_last_q  <= 1'b0;
         out_cout_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_sum_q   <= add_sum;
         if (last_d) begin
            out_last_q <= 1'b1;
            out_cout_q <= add_cout;
            out_err_q  <= trunc_d;
            carry_q    <= 1'b0;
            state_q    <= FIRST;
            cnt_q      <= '0;
         end else begin
            out_last_q <= 1'b0;
            out_cout_q <= 1'b0;
            out_err_q  <= 1'b0;
            carry_q    <= add_cout;
            state_q    <= MID;
            cnt_q      <= cnt_q + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_last  = out_last_q;
   assign out_cout  = out_cout_q;
   assign out_err   = out_err_q;

endmodule
